// File: rtl/aes_key_schedule_seq_pkg.sv
// rtl/aes_key_schedule_seq_pkg.sv - shared AES constants, key-length enum and GF(2^8) helpers
package aes_key_schedule_seq_pkg;
  localparam int WORD_W  = 32;
  localparam int KEY_W   = 256;
  localparam int BLOCK_W = 128;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2, KL_BAD = 2'd3} key_len_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  function automatic logic [3:0] nk_of(key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Window slot holding w[i-Nk] when the newest word sits in slot 7.
  function automatic logic [2:0] old_idx_of(key_len_e kl);
    case (kl)
      KL_192:  return 3'd2;
      KL_256:  return 3'd0;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map
module aes_sbox
  import aes_key_schedule_seq_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] s
);
  function automatic logic [7:0] sbox_f(logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    // Product of a^2, a^4 ... a^128 is a^254, the inverse (0 maps to 0).
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign s = sbox_f(x);
endmodule

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - SubWord: four S-boxes applied bytewise to one 32-bit word
module aes_subword (
  input  logic [31:0] w,
  output logic [31:0] sw
);
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.x(w[8*b +: 8]), .s(sw[8*b +: 8]));
  end
endmodule

// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - sequential AES-128/192/256 key expansion, one word per cycle, round-key stream out
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
#(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit STALL_FREE  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               start_ready,
  input  logic [1:0]         key_len,
  input  logic [KEY_W-1:0]   key,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [BLOCK_W-1:0] rk_data,
  output logic [3:0]         rk_index,
  output logic               rk_last,
  output logic               busy,
  output logic               err
);
  state_e              state;
  logic [WORD_W-1:0]   win [8];
  logic [BLOCK_W-1:0]  pack;
  logic [2:0]          pcnt;
  logic [5:0]          i_cnt;
  logic [2:0]          m_cnt;
  logic [3:0]          nk, nr, next_idx;
  logic [2:0]          old_idx;
  logic [7:0]          rcon;

  key_len_e            kl;
  logic                ready_eff, legal, accept, xfer, gen, gen_phase, rot_case, sub_case;
  logic [WORD_W-1:0]   prev_w, sw_in, sw_out, t_word, new_word;

  assign kl        = key_len_e'(key_len);
  assign ready_eff = STALL_FREE ? 1'b1 : rk_ready;
  assign legal     = (kl == KL_128) || (kl == KL_256) || (SUPPORT_192 && (kl == KL_192));
  assign accept    = start && start_ready && legal;
  assign xfer      = (pcnt == 3'd4) && (!rk_valid || ready_eff);
  // A full pack register freezes generation until it can move to rk_data.
  assign gen       = (state == S_RUN) && ((pcnt != 3'd4) || xfer);
  assign gen_phase = i_cnt >= {2'b00, nk};
  assign rot_case  = (m_cnt == 3'd0);
  assign sub_case  = (nk == 4'd8) && (m_cnt == 3'd4);
  assign prev_w    = win[7];
  assign sw_in     = rot_case ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_subword u_subword (.w(sw_in), .sw(sw_out));

  always_comb begin
    t_word = prev_w;
    if (rot_case)      t_word = sw_out ^ {rcon, 24'h000000};
    else if (sub_case) t_word = sw_out;
  end

  // Key words rotate out of slot 0; after Nk of them the window holds w0..w(Nk-1) at the top.
  assign new_word = gen_phase ? (win[old_idx] ^ t_word) : win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      for (int k = 0; k < 8; k++) win[k] <= '0;
      pack        <= '0;
      pcnt        <= 3'd0;
      i_cnt       <= 6'd0;
      m_cnt       <= 3'd0;
      nk          <= 4'd4;
      nr          <= 4'd10;
      next_idx    <= 4'd0;
      old_idx     <= 3'd4;
      rcon        <= RCON[0];
      start_ready <= 1'b1;
      rk_valid    <= 1'b0;
      rk_data     <= '0;
      rk_index    <= 4'd0;
      rk_last     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= start && start_ready && !legal;

      case (state)
        S_IDLE: if (accept) begin
          for (int k = 0; k < 8; k++) win[k] <= key[KEY_W-1-32*k -: 32];
          nk          <= nk_of(kl);
          nr          <= nr_of(kl);
          old_idx     <= old_idx_of(kl);
          i_cnt       <= 6'd0;
          m_cnt       <= 3'd0;
          rcon        <= RCON[0];
          pcnt        <= 3'd0;
          next_idx    <= 4'd0;
          start_ready <= 1'b0;
          busy        <= 1'b1;
          state       <= S_RUN;
        end
        S_RUN: if (gen && (i_cnt == {nr, 2'b11})) state <= S_DRAIN;
        S_DRAIN: if (rk_valid && rk_last && ready_eff) begin
          start_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (gen) begin
        for (int k = 0; k < 7; k++) win[k] <= win[k+1];
        win[7] <= new_word;
        pack   <= {pack[BLOCK_W-WORD_W-1:0], new_word};
        i_cnt  <= i_cnt + 6'd1;
        m_cnt  <= ({1'b0, m_cnt} == (nk - 4'd1)) ? 3'd0 : m_cnt + 3'd1;
        if (gen_phase && rot_case) rcon <= xtime(rcon);
        pcnt   <= xfer ? 3'd1 : pcnt + 3'd1;
      end else if (xfer) begin
        pcnt   <= 3'd0;
      end

      if (xfer) begin
        rk_data  <= pack;
        rk_index <= next_idx;
        rk_last  <= (next_idx == nr);
        next_idx <= next_idx + 4'd1;
        rk_valid <= 1'b1;
      end else if (ready_eff) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb/tb_aes_key_schedule_seq.sv - scoreboard bench: FIPS-style reference expansion vs streamed round keys
module tb_aes_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start0 = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         rk_ready = 1'b1;

  logic         start_ready, rk_valid, rk_last, busy, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         start_ready_0, rk_valid_0, rk_last_0, busy_0, err_0;
  logic [127:0] rk_data_0;
  logic [3:0]   rk_index_0;

  always #5 clk = ~clk;

  aes_key_schedule_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .key_len(key_len), .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last), .busy(busy), .err(err)
  );

  aes_key_schedule_seq #(.SUPPORT_192(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .start_ready(start_ready_0),
    .key_len(key_len), .key(key), .rk_valid(rk_valid_0), .rk_ready(rk_ready),
    .rk_data(rk_data_0), .rk_index(rk_index_0), .rk_last(rk_last_0), .busy(busy_0), .err(err_0)
  );

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef struct {
    logic [127:0] data;
    logic [3:0]   idx;
    logic         last;
  } exp_t;
  exp_t exp_q [$];

  int errors = 0;
  int checks = 0;
  logic [127:0] got [16];
  int n_got = 0;
  logic         held = 1'b0;
  logic [127:0] hold_data;
  logic [3:0]   hold_idx;
  logic         hold_last;

  function automatic logic [7:0] sb(logic [7:0] b);
    return sbox_flat[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic push_expected(input logic [255:0] k, input int nk);
    logic [31:0] w [60];
    logic [31:0] temp;
    exp_t e;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) temp = subw({temp[23:0], temp[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk > 6 && i % nk == 4) temp = subw(temp);
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r <= nr; r++) begin
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.idx  = 4'(r);
      e.last = (r == nr);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor: pops one expectation per handshake, checks holding while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if ({rk_valid, rk_data, rk_index, rk_last} !== {1'b1, hold_data, hold_idx, hold_last}) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h idx=%0d last=%0b want v=1 %h idx=%0d last=%0b",
                   rk_valid, rk_data, rk_index, rk_last, hold_data, hold_idx, hold_last);
        end
      end
      if (rk_valid && rk_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rk: got %h idx=%0d, want no round key", rk_data, rk_index);
        end else begin
          e = exp_q.pop_front();
          if ({rk_data, rk_index, rk_last, busy} !== {e.data, e.idx, e.last, 1'b1}) begin
            errors++;
            $display("FAIL rk_stream: got %h idx=%0d last=%0b busy=%0b want %h idx=%0d last=%0b busy=1",
                     rk_data, rk_index, rk_last, busy, e.data, e.idx, e.last);
          end
          got[rk_index] = rk_data;
          n_got++;
        end
      end
      held      = rk_valid && !rk_ready;
      hold_data = rk_data;
      hold_idx  = rk_index;
      hold_last = rk_last;
    end
  end

  task automatic kick(input logic [255:0] k, input logic [1:0] kl, input bit to_dut0);
    @(posedge clk); #1;
    key = k;
    key_len = kl;
    if (to_dut0) start0 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start0 = 1'b0;
    key    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, want 0", name, busy, c);
    end
  endtask

  task automatic end_checks(input string name, input int n_exp);
    checks++;
    if (n_got !== n_exp || exp_q.size() !== 0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_count: got keys=%0d left=%0d start_ready=%0b want keys=%0d left=0 start_ready=1",
               name, n_got, exp_q.size(), start_ready, n_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({start_ready, rk_valid, rk_last, busy, err, rk_data, rk_index} !== {1'b1, 4'b0, 128'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: got sr=%0b v=%0b l=%0b b=%0b e=%0b d=%h i=%0d want sr=1 others 0",
               start_ready, rk_valid, rk_last, busy, err, rk_data, rk_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aes128();
    int lat;
    n_got = 0;
    rk_ready = 1'b1;
    push_expected(KEY128, 4);
    kick(KEY128, 2'd0, 1'b0);
    checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      errors++;
      $display("FAIL aes128_accept: got busy=%0b start_ready=%0b want busy=1 start_ready=0", busy, start_ready);
    end
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (rk_valid) lat = n;
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL aes128_latency: got %0d cycles want 5", lat);
    end
    wait_idle("aes128");
    end_checks("aes128", 11);
    checks++;
    if (got[1] !== 128'ha0fafe1788542cb123a339392a6c7605 || got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL aes128_vectors: got rk1=%h rk10=%h want a0fafe1788542cb123a339392a6c7605 d014f9a8c9ee2589e13f0cc8b6630ca6",
               got[1], got[10]);
    end
  endtask

  task automatic test_aes192();
    n_got = 0;
    push_expected(KEY192, 6);
    kick(KEY192, 2'd1, 1'b0);
    wait_idle("aes192");
    end_checks("aes192", 13);
    checks++;
    if (got[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      errors++;
      $display("FAIL aes192_rk12: got %h want e98ba06f448c773c8ecc720401002202", got[12]);
    end
  endtask

  task automatic test_aes256();
    n_got = 0;
    push_expected(KEY256, 8);
    kick(KEY256, 2'd2, 1'b0);
    wait_idle("aes256");
    end_checks("aes256", 15);
    checks++;
    if (got[1] !== 128'h1f352c073b6108d72d9810a30914dff4 || got[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      errors++;
      $display("FAIL aes256_vectors: got rk1=%h rk14=%h want 1f352c073b6108d72d9810a30914dff4 fe4890d1e6188d0b046df344706c631e",
               got[1], got[14]);
    end
  endtask

  task automatic test_stall();
    int c;
    int stalls;
    n_got = 0;
    stalls = 0;
    c = 0;
    push_expected(KEY256, 8);
    kick(KEY256, 2'd2, 1'b0);
    while (busy && c < 2000) begin
      rk_ready = ($urandom_range(0, 99) >= 30);
      if (rk_valid && !rk_ready) stalls++;
      @(posedge clk); #1;
      c++;
    end
    rk_ready = 1'b1;
    checks++;
    if (busy !== 1'b0 || stalls == 0) begin
      errors++;
      $display("FAIL stall_run: got busy=%0b stalls=%0d want busy=0 stalls>0", busy, stalls);
    end
    end_checks("stall", 15);
    checks++;
    if (got[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      errors++;
      $display("FAIL stall_rk14: got %h want fe4890d1e6188d0b046df344706c631e", got[14]);
    end
  endtask

  task automatic test_illegal();
    int bad;
    kick(KEY128, 2'd3, 1'b0);
    checks++;
    if (err !== 1'b1 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal3_pulse: got err=%0b sr=%0b busy=%0b want err=1 sr=1 busy=0", err, start_ready, busy);
    end
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (err || rk_valid || busy || !start_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL illegal3_after: got %0d bad cycles want 0", bad);
    end
    kick(KEY192, 2'd1, 1'b1);
    checks++;
    if (err_0 !== 1'b1 || start_ready_0 !== 1'b1 || busy_0 !== 1'b0) begin
      errors++;
      $display("FAIL no192_pulse: got err=%0b sr=%0b busy=%0b want err=1 sr=1 busy=0", err_0, start_ready_0, busy_0);
    end
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (err_0 || rk_valid_0 || busy_0 || rk_last_0 || rk_data_0 != 0 || rk_index_0 != 0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL no192_after: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    n_got = 0;
    c = 0;
    push_expected(KEY128, 4);
    kick(KEY128, 2'd0, 1'b0);
    while (!(rk_valid && rk_index == 4'd5) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (!(rk_valid && rk_index == 4'd5)) begin
      errors++;
      $display("FAIL midreset_reach: got v=%0b idx=%0d want v=1 idx=5", rk_valid, rk_index);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_ready, rk_valid, rk_last, busy, err, rk_data, rk_index} !== {1'b1, 4'b0, 128'h0, 4'h0}) begin
      errors++;
      $display("FAIL midreset_state: got sr=%0b v=%0b l=%0b b=%0b e=%0b d=%h i=%0d want sr=1 others 0",
               start_ready, rk_valid, rk_last, busy, err, rk_data, rk_index);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n_got = 0;
    push_expected(KEY128, 4);
    kick(KEY128, 2'd0, 1'b0);
    wait_idle("midreset");
    end_checks("midreset", 11);
    checks++;
    if (got[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++;
      $display("FAIL midreset_rk0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", got[0]);
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
